tinyalu_param: RTL and testbench

// - Parametrised successor of the TinyALU: WIDTH-bit operands, 2*WIDTH-bit result, configurable multiply latency.
// - Single FSM-controlled datapath replacing the split single/three-cycle units; adds busy back-pressure and an operand capture register.
// - Sits between the bus-side command driver and the result monitor; start/done handshake is unchanged for existing benches.

---
 rtl/tinyalu_param_if.sv | 31 +++
 rtl/tinyalu_param.sv | 139 +++++++++++++
 tb/tb_tinyalu_param.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/tinyalu_param_if.sv
// Command/result bus of tinyalu_param: the driver side is master, the ALU is slave.
// The optional status flags are present only when TINYALU_P_STATUS_EN is defined.
interface tinyalu_param_if #(
   parameter int WIDTH = 8
);
   // start is a request that is taken on any rising edge where busy is low.
   // done pulses exactly once per taken command, with result valid in that cycle.
   logic                 start;
   logic [2:0]           op;
   logic [WIDTH-1:0]     A;
   logic [WIDTH-1:0]     B;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   result;
   logic                 state_dbg;
`ifdef TINYALU_P_STATUS_EN
   logic                 zero;
   logic                 carry;
   logic                 illegal;

   modport master (output start, op, A, B,
                   input  busy, done, result, state_dbg, zero, carry, illegal);
   modport slave  (input  start, op, A, B,
                   output busy, done, result, state_dbg, zero, carry, illegal);
`else
   modport master (output start, op, A, B,
                   input  busy, done, result, state_dbg);
   modport slave  (input  start, op, A, B,
                   output busy, done, result, state_dbg);
`endif
endinterface

// File: rtl/tinyalu_param.sv
// Parametrised TinyALU: ADD/AND/XOR/NOP in one cycle, MUL in MULT_LAT cycles with busy.
// Defining TINYALU_P_STATUS_EN adds zero/carry/illegal flags qualified by done.
module tinyalu_param #(
   parameter int WIDTH    = 8,
   parameter int MULT_LAT = 3
) (
   input  logic           clk,
   input  logic           reset_n,
   tinyalu_param_if.slave bus
);
   localparam int RW = 2 * WIDTH;

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_XOR = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;

   typedef enum logic {
      IDLE    = 1'b0,
      MUL_RUN = 1'b1
   } state_e;

   state_e           state_q;
   logic [3:0]       cnt_q;
   logic             busy_q;
   logic             done_q;
   logic [RW-1:0]    result_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [2:0]       op_q;

   logic             accept;
   logic             long_mul;
   logic [WIDTH:0]   sum_d;
   logic [RW-1:0]    alu_d;
   logic [RW-1:0]    mul_run_d;

   assign accept    = bus.start && !busy_q;
   assign long_mul  = (bus.op == OP_MUL) && (MULT_LAT > 1);
   assign sum_d     = {1'b0, bus.A} + {1'b0, bus.B};
   assign mul_run_d = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

   // Single-cycle result straight from the bus operands; NOP re-issues the held result.
   always_comb begin
      alu_d = '0;
      case (bus.op)
         OP_NOP:  alu_d = result_q;
         OP_ADD:  alu_d = {{(WIDTH-1){1'b0}}, sum_d};
         OP_AND:  alu_d = {{WIDTH{1'b0}}, bus.A & bus.B};
         OP_XOR:  alu_d = {{WIDTH{1'b0}}, bus.A ^ bus.B};
         OP_MUL:  alu_d = {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B};
         default: alu_d = '0;
      endcase
   end

`ifdef TINYALU_P_STATUS_EN
   logic zero_q;
   logic carry_q;
   logic illegal_q;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
`ifdef TINYALU_P_STATUS_EN
         zero_q    <= 1'b0;
         carry_q   <= 1'b0;
         illegal_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
`ifdef TINYALU_P_STATUS_EN
         zero_q    <= 1'b0;
         carry_q   <= 1'b0;
         illegal_q <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               if (accept) begin
                  a_q  <= bus.A;
                  b_q  <= bus.B;
                  op_q <= bus.op;
                  if (long_mul) begin
                     state_q <= MUL_RUN;
                     cnt_q   <= 4'(MULT_LAT - 1);
                     busy_q  <= 1'b1;
                  end else begin
                     done_q   <= 1'b1;
                     result_q <= alu_d;
`ifdef TINYALU_P_STATUS_EN
                     zero_q    <= (alu_d == '0);
                     carry_q   <= (bus.op == OP_ADD) && sum_d[WIDTH];
                     illegal_q <= (bus.op > OP_MUL);
`endif
                  end
               end
            end
            MUL_RUN: begin
               // Count 1 is the last busy cycle: the product lands together with done.
               if (cnt_q == 4'd1) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  if (op_q == OP_MUL) begin
                     result_q <= mul_run_d;
                  end
`ifdef TINYALU_P_STATUS_EN
                  zero_q <= (mul_run_d == '0);
`endif
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.result    = result_q;
   assign bus.state_dbg = (state_q == MUL_RUN);
`ifdef TINYALU_P_STATUS_EN
   assign bus.zero      = zero_q;
   assign bus.carry     = carry_q;
   assign bus.illegal   = illegal_q;
`endif
endmodule

// File: tb/tb_tinyalu_param.sv
// Bench for tinyalu_param: directed steps then random traffic against a cycle-level reference.
// Covers both WIDTH=8/MULT_LAT=3 and WIDTH=16/MULT_LAT=1 instances; honours TINYALU_P_STATUS_EN.
module tb_tinyalu_param;
   localparam int LAT = 3;

   logic clk;
   logic reset_n;
   int   checks;
   int   errors;

   tinyalu_param_if #(.WIDTH(8))  bus8 ();
   tinyalu_param_if #(.WIDTH(16)) bus16 ();

   tinyalu_param #(.WIDTH(8), .MULT_LAT(LAT)) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus8)
   );

   tinyalu_param #(.WIDTH(16), .MULT_LAT(1)) u_dut16 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference state: what the ALU has promised but not yet delivered.
   logic [15:0] exp_q[$];
   logic [15:0] m_result;
   logic [15:0] m_pending;
   int          m_left;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] ref_alu(input logic [2:0] o, input logic [7:0] a,
                                           input logic [7:0] b, input logic [15:0] prev);
      int ia;
      int ib;
      ia = int'(a);
      ib = int'(b);
      case (o)
         3'd0:    return prev;
         3'd1:    return 16'(ia + ib);
         3'd2:    return 16'(ia & ib);
         3'd3:    return 16'(ia ^ ib);
         3'd4:    return 16'(ia * ib);
         default: return 16'h0000;
      endcase
   endfunction

   // Present one set of inputs to the 8-bit ALU, clock once, advance the model and compare.
   task automatic step(input logic st, input logic [2:0] o, input logic [7:0] a,
                       input logic [7:0] b, input logic rn);
      logic        exp_done;
      logic        exp_carry;
      logic        exp_illegal;
      logic [15:0] v;
      bus8.start = st;
      bus8.op    = o;
      bus8.A     = a;
      bus8.B     = b;
      reset_n    = rn;
      @(posedge clk);
      #1;
      exp_done    = 1'b0;
      exp_carry   = 1'b0;
      exp_illegal = 1'b0;
      if (!rn) begin
         m_result = 16'h0000;
         m_left   = 0;
         exp_q.delete();
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) begin
            exp_done = 1'b1;
            m_result = m_pending;
         end
      end else if (st) begin
         v = ref_alu(o, a, b, m_result);
         exp_q.push_back(v);
         if (o == 3'd4 && LAT > 1) begin
            m_left    = LAT - 1;
            m_pending = v;
         end else begin
            exp_done    = 1'b1;
            m_result    = v;
            exp_carry   = (o == 3'd1) && (int'(a) + int'(b) > 255);
            exp_illegal = (o > 3'd4);
         end
      end
      check("done", 32'(bus8.done), 32'(exp_done));
      check("busy", 32'(bus8.busy), 32'(m_left > 0));
      check("state_dbg", 32'(bus8.state_dbg), 32'(m_left > 0));
      check("result", 32'(bus8.result), 32'(m_result));
      if (bus8.done) begin
         check("sb_pending", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            v = exp_q.pop_front();
            check("sb_result", 32'(bus8.result), 32'(v));
         end
      end
`ifdef TINYALU_P_STATUS_EN
      check("zero", 32'(bus8.zero), 32'(exp_done && (m_result == 16'h0000)));
      check("carry", 32'(bus8.carry), 32'(exp_carry));
      check("illegal", 32'(bus8.illegal), 32'(exp_illegal));
`else
      if (exp_carry || exp_illegal) v = 16'h0000;
`endif
   endtask

   initial begin
      logic       st;
      logic       rn;
      logic [2:0] o;
      logic [7:0] a;
      logic [7:0] b;
      checks     = 0;
      errors     = 0;
      m_result   = 16'h0000;
      m_pending  = 16'h0000;
      m_left     = 0;
      reset_n    = 1'b0;
      bus8.start = 1'b0;
      bus8.op    = 3'd0;
      bus8.A     = 8'h00;
      bus8.B     = 8'h00;
      bus16.start = 1'b0;
      bus16.op    = 3'd0;
      bus16.A     = 16'h0000;
      bus16.B     = 16'h0000;

      // Reset held two cycles with start asserted.
      step(1'b1, 3'd1, 8'h12, 8'h34, 1'b0);
      step(1'b1, 3'd1, 8'h12, 8'h34, 1'b0);
      check("rst_result16", bus16.result, 32'h0);
      check("rst_busy16", 32'(bus16.busy), 32'd0);

      // ADD back-to-back.
      step(1'b1, 3'd1, 8'hFF, 8'h01, 1'b1);
      check("add_ff_01", 32'(bus8.result), 32'h0100);
      step(1'b1, 3'd1, 8'h10, 8'h20, 1'b1);
      check("add_10_20", 32'(bus8.result), 32'h0030);
      check("add_b2b_done", 32'(bus8.done), 32'd1);

      // MUL latency, busy and an ignored start.
      step(1'b1, 3'd4, 8'hFF, 8'hFF, 1'b1);
      step(1'b1, 3'd3, 8'h0F, 8'hF0, 1'b1);
      step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
      check("mul_ff_ff", 32'(bus8.result), 32'hFE01);
      check("mul_done_k3", 32'(bus8.done), 32'd1);
      step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
      check("xor_ignored", 32'(bus8.done), 32'd0);

      // Reset in the middle of a MUL.
      step(1'b1, 3'd4, 8'h03, 8'h04, 1'b1);
      step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
      step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
      step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
      check("abort_result", 32'(bus8.result), 32'h0000);
      step(1'b1, 3'd1, 8'h01, 8'h01, 1'b1);
      check("add_1_1", 32'(bus8.result), 32'h0002);

      // NOP holds, illegal zeroes.
      step(1'b1, 3'd1, 8'h10, 8'h20, 1'b1);
      step(1'b1, 3'd0, 8'hAA, 8'h55, 1'b1);
      check("nop_hold", 32'(bus8.result), 32'h0030);
      step(1'b1, 3'd6, 8'hAA, 8'h55, 1'b1);
      check("illegal_zero", 32'(bus8.result), 32'h0000);
`ifdef TINYALU_P_STATUS_EN
      check("illegal_flag", 32'(bus8.illegal), 32'd1);
`endif
      step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);

      // WIDTH=16, MULT_LAT=1: MUL behaves like a single-cycle op.
      bus16.start = 1'b1;
      bus16.op    = 3'd4;
      bus16.A     = 16'hFFFF;
      bus16.B     = 16'h0002;
      step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
      bus16.start = 1'b0;
      check("w16_done", 32'(bus16.done), 32'd1);
      check("w16_result", bus16.result, 32'h0001FFFE);
      check("w16_busy", 32'(bus16.busy), 32'd0);
      step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
      check("w16_single_done", 32'(bus16.done), 32'd0);
      check("w16_busy_after", 32'(bus16.busy), 32'd0);
      check("w16_hold", bus16.result, 32'h0001FFFE);

      // Random traffic, including starts during busy and rare resets.
      for (int i = 0; i < 400; i++) begin
         rn = ($urandom_range(0, 63) != 0);
         st = 1'($urandom_range(0, 1));
         o  = 3'($urandom_range(0, 7));
         a  = 8'($urandom);
         b  = 8'($urandom);
         step(st, o, a, b, rn);
      end

      for (int i = 0; i < 8; i++) begin
         step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
      end
      check("sb_drain", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
